// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and decoder for the seven-segment capture monitor.
// Bit order of a pattern: bit0 = segment a ... bit6 = segment g, active-high lit.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_BLANK   = 7'h00;
    localparam seg7_t SEG7_GLYPH_0 = 7'h3F;
    localparam seg7_t SEG7_GLYPH_1 = 7'h06;
    localparam seg7_t SEG7_GLYPH_2 = 7'h5B;
    localparam seg7_t SEG7_GLYPH_3 = 7'h4F;
    localparam seg7_t SEG7_GLYPH_4 = 7'h66;
    localparam seg7_t SEG7_GLYPH_5 = 7'h6D;
    localparam seg7_t SEG7_GLYPH_6 = 7'h7D;
    localparam seg7_t SEG7_GLYPH_7 = 7'h07;
    localparam seg7_t SEG7_GLYPH_8 = 7'h7F;
    localparam seg7_t SEG7_GLYPH_9 = 7'h6F;
    localparam seg7_t SEG7_GLYPH_A = 7'h77;
    localparam seg7_t SEG7_GLYPH_B = 7'h7C;
    localparam seg7_t SEG7_GLYPH_C = 7'h39;
    localparam seg7_t SEG7_GLYPH_D = 7'h5E;
    localparam seg7_t SEG7_GLYPH_E = 7'h79;
    localparam seg7_t SEG7_GLYPH_F = 7'h71;

    typedef struct packed {
        logic       known;
        logic [3:0] digit;
        seg7_t      raw;
    } seg7_evt_t;

    typedef enum logic {
        FILT_TRACK = 1'b0,
        FILT_HELD  = 1'b1
    } seg7_filt_state_t;

    // Returns {known, digit}; unrecognised patterns (blank included) give 5'h00.
    function automatic logic [4:0] seg7_decode(input seg7_t pat);
        case (pat)
            SEG7_GLYPH_0: seg7_decode = {1'b1, 4'h0};
            SEG7_GLYPH_1: seg7_decode = {1'b1, 4'h1};
            SEG7_GLYPH_2: seg7_decode = {1'b1, 4'h2};
            SEG7_GLYPH_3: seg7_decode = {1'b1, 4'h3};
            SEG7_GLYPH_4: seg7_decode = {1'b1, 4'h4};
            SEG7_GLYPH_5: seg7_decode = {1'b1, 4'h5};
            SEG7_GLYPH_6: seg7_decode = {1'b1, 4'h6};
            SEG7_GLYPH_7: seg7_decode = {1'b1, 4'h7};
            SEG7_GLYPH_8: seg7_decode = {1'b1, 4'h8};
            SEG7_GLYPH_9: seg7_decode = {1'b1, 4'h9};
            SEG7_GLYPH_A: seg7_decode = {1'b1, 4'hA};
            SEG7_GLYPH_B: seg7_decode = {1'b1, 4'hB};
            SEG7_GLYPH_C: seg7_decode = {1'b1, 4'hC};
            SEG7_GLYPH_D: seg7_decode = {1'b1, 4'hD};
            SEG7_GLYPH_E: seg7_decode = {1'b1, 4'hE};
            SEG7_GLYPH_F: seg7_decode = {1'b1, 4'hF};
            default:      seg7_decode = 5'h00;
        endcase
    endfunction

endpackage

// File: rtl/seg7_capture_monitor_if.sv
// Decoded-event stream: the monitor is master (valid + payload), the consumer is slave (ready).
// Payload is only meaningful while evt_valid is high and is held until evt_ready.
interface seg7_capture_monitor_if;
    import seg7_pkg::*;

    logic       evt_valid;
    logic       evt_ready;
    logic       evt_known;
    logic [3:0] evt_digit;
    seg7_t      evt_raw;

    modport master (
        output evt_valid,
        output evt_known,
        output evt_digit,
        output evt_raw,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_known,
        input  evt_digit,
        input  evt_raw,
        output evt_ready
    );
endinterface

// File: rtl/seg7_evt_fifo.sv
// Synchronous event FIFO of seg7_evt_t with a sticky overflow flag.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: head holds while out_vld && !out_rdy; a push into a full queue without a pop is dropped.
module seg7_evt_fifo
    import seg7_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  seg7_evt_t push_dat,
    output logic      out_vld,
    input  logic      out_rdy,
    output seg7_evt_t out_dat,
    output logic      overflow
);
    localparam int AW = $clog2(DEPTH);

    seg7_evt_t       mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            full;
    logic            pop;
    logic            wr_en;

    assign out_vld = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = out_vld && out_rdy;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign wr_en   = push && (!full || pop);
    assign out_dat = out_vld ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (push && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/seg7_capture_monitor.sv
// Seven-segment bus monitor: 2-flop sync, glitch filter, hex decode, event FIFO. Option: SEG7_CAPTURE_ACTIVE_LOW_EN.
// Latency: a held change reaches evt_valid 2 + STABLE_CYCLES + 1 cycles later (empty FIFO).
// Backpressure: events queue while evt_ready is low; when the queue is full new events drop and overflow sticks.
module seg7_capture_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  seg7_t                         seg_in,
    seg7_capture_monitor_if.master        evt,
    output logic                          overflow,
    output logic [7:0]                    evt_count,
    output logic [7:0]                    bad_count
);
`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
    // Common-anode targets drive low to light a segment; all-high is blank.
    localparam seg7_t SYNC_RST = 7'h7F;
    seg7_t seg_pol;
    assign seg_pol = ~seg_in;
`else
    localparam seg7_t SYNC_RST = SEG7_BLANK;
    seg7_t seg_pol;
    assign seg_pol = seg_in;
`endif

    seg7_t             sync1_q;
    seg7_t             s2_q;
    seg7_filt_state_t  state_q, state_d;
    seg7_t             cand_q, cand_d;
    logic [7:0]        cnt_q, cnt_d;
    seg7_t             last_q;
    logic              accept;
    logic [4:0]        dec;
    seg7_evt_t         push_dat;
    seg7_evt_t         head;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= SYNC_RST;
            s2_q    <= SYNC_RST;
        end else begin
            sync1_q <= seg_pol;
            s2_q    <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILT_TRACK;
            cand_q  <= SEG7_BLANK;
            cnt_q   <= 8'd0;
            last_q  <= SEG7_BLANK;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                last_q <= cand_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            FILT_TRACK: begin
                if (s2_q != cand_q) begin
                    cand_d = s2_q;
                    cnt_d  = 8'd0;
                end else if (cnt_q == 8'(STABLE_CYCLES - 1)) begin
                    state_d = FILT_HELD;
                    // Settling back onto the pattern already reported is not a new event.
                    accept  = (cand_q != last_q);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FILT_HELD: begin
                if (s2_q != cand_q) begin
                    state_d = FILT_TRACK;
                    cand_d  = s2_q;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = FILT_TRACK;
            end
        endcase
    end

    assign dec      = seg7_decode(cand_q);
    assign push_dat = '{known: dec[4], digit: dec[3:0], raw: cand_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_count <= 8'd0;
            bad_count <= 8'd0;
        end else if (accept) begin
            evt_count <= evt_count + 8'd1;
            if (!dec[4] && (bad_count != 8'hFF)) begin
                bad_count <= bad_count + 8'd1;
            end
        end
    end

    seg7_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_dat (push_dat),
        .out_vld  (evt.evt_valid),
        .out_rdy  (evt.evt_ready),
        .out_dat  (head),
        .overflow (overflow)
    );

    assign evt.evt_known = head.known;
    assign evt.evt_digit = head.digit;
    assign evt.evt_raw   = head.raw;
endmodule
